// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: grant state
// encoding and arbitration mode selectors.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam int ARB_RR   = 0;
    localparam int ARB_PRIO = 1;

endpackage

// File: rtl/wb_watchdog.sv
// Stall watchdog for the arbitrated slave port. It counts strobed cycles
// without ack. At all-ones it raises a one-cycle error and then masks the
// strobe until the owner backs off.
module wb_watchdog #(
    parameter int TMO_BITS = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,      // grant change or no owner
    input  logic own_stb_i,  // owner's raw strobe
    input  logic own_cyc_i,  // owner's raw cycle
    input  logic ack_i,      // slave acknowledge
    output logic err_o,
    output logic abort_o
);

    logic [TMO_BITS-1:0] tmo_q, tmo_d;
    logic                abort_q, abort_d;
    logic                stb_eff;
    logic                tmo_max;

    assign stb_eff = own_stb_i & ~abort_q;
    assign tmo_max = &tmo_q;
    // An ack arriving on the all-ones cycle wins over the error.
    assign err_o   = tmo_max & stb_eff & ~ack_i;
    assign abort_o = abort_q;

    // Next-state for the stall counter and abort flag.
    always_comb begin
        tmo_d   = tmo_q;
        abort_d = abort_q;
        if (clr_i) begin
            tmo_d   = '0;
            abort_d = 1'b0;
        end else if (abort_q) begin
            // Once the owner backs off, restart from zero so that a fresh
            // strobe under the same cyc gets a full timeout window.
            if (!own_stb_i || !own_cyc_i) begin
                abort_d = 1'b0;
                tmo_d   = '0;
            end
        end else if (ack_i) begin
            tmo_d = '0;
        end else if (err_o) begin
            abort_d = 1'b1;
        end else if (stb_eff && !tmo_max) begin
            tmo_d = tmo_q + TMO_BITS'(1);
        end
    end

    // Watchdog state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: rtl/wb_arb2.sv
// Two-master / one-slave Wishbone arbiter. The grant is held for the whole
// cyc of the owner, and handoff to a waiting master is direct. The ack is
// routed only to the owner. Stalled accesses are aborted by wb_watchdog.
module wb_arb2
    import wb_arb_pkg::*;
#(
    parameter int AW       = 19,
    parameter int DW       = 16,
    parameter int SW       = 2,
    parameter int ARB_MODE = ARB_RR,
    parameter int TMO_BITS = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    // master 0
    input  logic [AW:1]   m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    input  logic [SW-1:0] m0_sel_i,
    input  logic          m0_we_i,
    input  logic          m0_tga_i,
    input  logic          m0_stb_i,
    input  logic          m0_cyc_i,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    // master 1
    input  logic [AW:1]   m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    input  logic [SW-1:0] m1_sel_i,
    input  logic          m1_we_i,
    input  logic          m1_tga_i,
    input  logic          m1_stb_i,
    input  logic          m1_cyc_i,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    // slave
    output logic [AW:1]   s_adr_o,
    output logic [DW-1:0] s_dat_o,
    output logic [SW-1:0] s_sel_o,
    output logic          s_we_o,
    output logic          s_tga_o,
    output logic          s_stb_o,
    output logic          s_cyc_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    // debug
    output logic [1:0]    gnt_o
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic [1:0] gnt_q, gnt_d;
    logic       arb_en;
    logic       grant1;
    logic       own_stb, own_cyc;
    logic       wd_clr, wd_err, abort;

    // Grant next-state: arbitrate only when idle or when the owner has released cyc.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant1  = 1'b0;
        arb_en  = (state_q == ST_IDLE)
               || (state_q == ST_OWN0 && !m0_cyc_i)
               || (state_q == ST_OWN1 && !m1_cyc_i);
        if (arb_en) begin
            if (m0_cyc_i && m1_cyc_i) begin
                // Round-robin gives the tie to the master that did not win last.
                grant1 = (ARB_MODE == ARB_PRIO) ? 1'b0 : ~last_q;
            end else begin
                grant1 = m1_cyc_i;
            end
            if (m0_cyc_i || m1_cyc_i) begin
                state_d = grant1 ? ST_OWN1 : ST_OWN0;
                last_d  = grant1;
            end else begin
                state_d = ST_IDLE;
            end
        end
        gnt_d = {state_d == ST_OWN1, state_d == ST_OWN0};
    end

    // Grant state, round-robin memory and the registered one-hot grant.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
        end
    end

    // Slave-side mux, steered by the registered grant; all-zero with no owner.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_tga_o = 1'b0;
        own_stb = 1'b0;
        own_cyc = 1'b0;
        if (gnt_q[0]) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
            s_tga_o = m0_tga_i;
            own_stb = m0_stb_i;
            own_cyc = m0_cyc_i;
        end else if (gnt_q[1]) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            s_tga_o = m1_tga_i;
            own_stb = m1_stb_i;
            own_cyc = m1_cyc_i;
        end
    end

    assign wd_clr = (state_q == ST_IDLE) || (state_d != state_q);

    wb_watchdog #(
        .TMO_BITS (TMO_BITS)
    ) u_wd (
        .clk_i     (wb_clk_i),
        .rst_n_i   (wb_rst_n_i),
        .clr_i     (wd_clr),
        .own_stb_i (own_stb),
        .own_cyc_i (own_cyc),
        .ack_i     (s_ack_i),
        .err_o     (wd_err),
        .abort_o   (abort)
    );

    assign s_stb_o  = own_stb & ~abort;
    assign s_cyc_o  = own_cyc;
    assign gnt_o    = gnt_q;

    // Read data is shared; only ack qualifies it.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = s_ack_i & gnt_q[0] & m0_stb_i & ~abort;
    assign m1_ack_o = s_ack_i & gnt_q[1] & m1_stb_i & ~abort;
    assign m0_err_o = wd_err & gnt_q[0];
    assign m1_err_o = wd_err & gnt_q[1];

endmodule

// File: tb/tb_wb_arb2.sv
// Directed bench for wb_arb2: a round-robin instance (checked through an
// ack/err scoreboard and inline checks) and a fixed-priority instance that
// shares the same stimulus.
module tb_wb_arb2;

    localparam int AW = 19;
    localparam int DW = 16;
    localparam int SW = 2;

    typedef struct packed {
        logic          is_err;
        logic          mst;
        logic [DW-1:0] dat;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [AW:1]   m0_adr, m1_adr;
    logic [DW-1:0] m0_wdat, m1_wdat, s_rdat;
    logic [SW-1:0] m0_sel, m1_sel;
    logic          m0_we, m1_we, m0_tga, m1_tga, m0_stb, m1_stb, m0_cyc, m1_cyc, s_ack;

    // round-robin DUT outputs
    logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o;
    logic          m0_ack, m1_ack, m0_err, m1_err;
    logic [AW:1]   s_adr;
    logic [SW-1:0] s_sel;
    logic          s_we, s_tga, s_stb, s_cyc;
    logic [1:0]    gnt;

    // fixed-priority DUT outputs
    logic [DW-1:0] p_m0_dat_o, p_m1_dat_o, p_s_dat_o;
    logic          p_m0_ack, p_m1_ack, p_m0_err, p_m1_err;
    logic [AW:1]   p_s_adr;
    logic [SW-1:0] p_s_sel;
    logic          p_s_we, p_s_tga, p_s_stb, p_s_cyc;
    logic [1:0]    p_gnt;

    int  tests = 0;
    int  fails = 0;
    ev_t sbq[$];

    wb_arb2 #(.AW(AW), .DW(DW), .SW(SW), .ARB_MODE(0), .TMO_BITS(4)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel),
        .m0_we_i(m0_we), .m0_tga_i(m0_tga), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel),
        .m1_we_i(m1_we), .m1_tga_i(m1_tga), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel), .s_we_o(s_we), .s_tga_o(s_tga),
        .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_dat_i(s_rdat), .s_ack_i(s_ack), .gnt_o(gnt)
    );

    wb_arb2 #(.AW(AW), .DW(DW), .SW(SW), .ARB_MODE(1), .TMO_BITS(4)) dut_p (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(p_m0_dat_o), .m0_sel_i(m0_sel),
        .m0_we_i(m0_we), .m0_tga_i(m0_tga), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
        .m0_ack_o(p_m0_ack), .m0_err_o(p_m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(p_m1_dat_o), .m1_sel_i(m1_sel),
        .m1_we_i(m1_we), .m1_tga_i(m1_tga), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
        .m1_ack_o(p_m1_ack), .m1_err_o(p_m1_err),
        .s_adr_o(p_s_adr), .s_dat_o(p_s_dat_o), .s_sel_o(p_s_sel), .s_we_o(p_s_we), .s_tga_o(p_s_tga),
        .s_stb_o(p_s_stb), .s_cyc_o(p_s_cyc), .s_dat_i(s_rdat), .s_ack_i(s_ack), .gnt_o(p_gnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic e, input logic m, input logic [DW-1:0] d);
        ev_t ev;
        ev.is_err = e;
        ev.mst    = m;
        ev.dat    = d;
        sbq.push_back(ev);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
        s_ack  = 1'b0;
    endtask

    // Monitor: every ack/err seen on the round-robin DUT must match the next expected event.
    always @(negedge clk) begin
        for (int x = 0; x < 2; x++) begin
            logic          a, e;
            logic [DW-1:0] d;
            ev_t           got, exp;
            a = (x == 0) ? m0_ack : m1_ack;
            e = (x == 0) ? m0_err : m1_err;
            d = (x == 0) ? m0_dat_o : m1_dat_o;
            if (a || e) begin
                tests++;
                got.is_err = e;
                got.mst    = (x == 1);
                got.dat    = a ? d : '0;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got m%0d ack=%0b err=%0b dat=%0h, expected no event", x, a, e, d);
                end else begin
                    exp = sbq.pop_front();
                    if (got !== exp || (a && e)) begin
                        fails++;
                        $display("FAIL sb_event: got err=%0b m%0d dat=%0h (ack=%0b), expected err=%0b m%0d dat=%0h",
                                 got.is_err, got.mst, got.dat, a, exp.is_err, exp.mst, exp.dat);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL tb_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        m0_adr = '0; m1_adr = '0; m0_wdat = '0; m1_wdat = '0; s_rdat = '0;
        m0_sel = 2'b11; m1_sel = 2'b11; m0_tga = 1'b0; m1_tga = 1'b0;
        clear_inputs();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_scyc_sstb", 32'({s_stb, s_cyc}), 32'h0);
        chk("reset_ack_err", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
        chk("reset_gnt_prio", 32'(p_gnt), 32'h0);

        // m1 alone, slave acks at once (ignored while idle)
        tick();
        rst_n = 1'b1;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 19'h00055;
        s_ack = 1'b1; s_rdat = 16'hBEEF;
        push(1'b0, 1'b1, 16'hBEEF);
        @(negedge clk);
        chk("gnt_before_edge", 32'(gnt), 32'h0);
        tick();
        @(negedge clk);
        chk("m1_gnt", 32'(gnt), 32'h2);
        chk("m1_sadr", 32'(s_adr), 32'h00055);
        chk("m1_sstb", 32'(s_stb), 32'h1);
        tick();
        clear_inputs();
        tick();
        @(negedge clk);
        chk("idle_after_release", 32'(gnt), 32'h0);

        // Fresh reset, then round-robin tie and direct handoff
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        tick();
        @(negedge clk);
        chk("rr_tie_gnt", 32'(gnt), 32'h1);
        chk("prio_tie_gnt", 32'(p_gnt), 32'h1);
        tick();
        m0_cyc = 1'b0;
        tick();
        @(negedge clk);
        chk("rr_handoff", 32'(gnt), 32'h2);
        chk("prio_handoff", 32'(p_gnt), 32'h2);
        tick();
        clear_inputs();
        tick();

        // Fixed priority vs round-robin on repeated ties
        m0_cyc = 1'b1;
        tick();
        m0_cyc = 1'b0;
        tick();
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        tick();
        @(negedge clk);
        chk("rr_tie_after_m0", 32'(gnt), 32'h2);
        chk("prio_tie_after_m0", 32'(p_gnt), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            m0_cyc = 1'b0; m1_cyc = 1'b0;
            tick();
            m0_cyc = 1'b1; m1_cyc = 1'b1;
            tick();
            @(negedge clk);
            chk($sformatf("prio_rerequest_%0d", i), 32'(p_gnt), 32'h1);
            chk($sformatf("rr_alternate_%0d", i), 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
        end
        tick();
        clear_inputs();
        tick();

        // Atomic hold: m1 keeps cyc for 4 beats while m0 waits
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 19'h12340; m1_wdat = 16'h5A5A;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 19'h00ABC;
        s_ack = 1'b1; s_rdat = 16'hA001;
        push(1'b0, 1'b1, 16'hA001);
        tick();
        @(negedge clk);
        chk("atomic_gnt_m1", 32'(gnt), 32'h2);
        chk("atomic_sadr_b1", 32'(s_adr), 32'h12340);
        chk("atomic_sdat_b1", 32'(s_dat_o), 32'h5A5A);
        for (int b = 2; b <= 4; b++) begin
            tick();
            s_rdat = 16'hA000 + 16'(b);
            push(1'b0, 1'b1, 16'hA000 + 16'(b));
            @(negedge clk);
            chk($sformatf("atomic_sadr_b%0d", b), 32'(s_adr), 32'h12340);
        end
        tick();
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
        s_rdat = 16'hB000;
        push(1'b0, 1'b0, 16'hB000);
        @(negedge clk);
        chk("atomic_m0_waits", 32'(gnt), 32'h2);
        tick();
        @(negedge clk);
        chk("atomic_m0_gnt", 32'(gnt), 32'h1);
        chk("atomic_m0_sadr", 32'(s_adr), 32'h00ABC);
        tick();
        clear_inputs();
        tick();

        // Watchdog: slave never acks
        m0_cyc = 1'b1; m0_stb = 1'b1;
        push(1'b1, 1'b0, 16'h0);
        tick();
        repeat (14) tick();
        @(negedge clk);
        chk("wd_no_err_at_14", 32'(m0_err), 32'h0);
        chk("wd_sstb_at_14", 32'(s_stb), 32'h1);
        tick();
        @(negedge clk);
        chk("wd_err_at_15", 32'(m0_err), 32'h1);
        tick();
        s_ack = 1'b1;
        @(negedge clk);
        chk("wd_err_once", 32'(m0_err), 32'h0);
        chk("wd_abort_mask", 32'(s_stb), 32'h0);
        chk("wd_abort_ack_ignored", 32'(m0_ack), 32'h0);
        tick();
        s_ack = 1'b0;
        m0_stb = 1'b0;
        @(negedge clk);
        chk("wd_sstb_stb_low", 32'(s_stb), 32'h0);
        tick();
        m0_stb = 1'b1;
        @(negedge clk);
        chk("wd_abort_release", 32'(s_stb), 32'h1);
        tick();
        clear_inputs();
        tick();

        // Watchdog: ack arriving on the all-ones cycle wins
        m0_cyc = 1'b1; m0_stb = 1'b1;
        tick();
        repeat (15) tick();
        s_ack = 1'b1; s_rdat = 16'hC0DE;
        push(1'b0, 1'b0, 16'hC0DE);
        @(negedge clk);
        chk("wd_ack_wins_err", 32'(m0_err), 32'h0);
        chk("wd_ack_wins_ack", 32'(m0_ack), 32'h1);
        tick();
        clear_inputs();
        tick();

        // Mid-access asynchronous reset
        m0_cyc = 1'b1; m0_stb = 1'b1;
        tick();
        @(negedge clk);
        chk("mid_pre_bus", 32'({s_stb, s_cyc}), 32'h3);
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bus_drop", 32'({s_stb, s_cyc}), 32'h0);
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rel_idle", 32'({gnt, s_cyc}), 32'h0);
        tick();
        @(negedge clk);
        chk("mid_regrant", 32'(gnt), 32'h1);
        tick();
        clear_inputs();
        tick();
        tick();

        chk("sb_drain", 32'(sbq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_arb2.md
# wb_arb2

Two-master, one-slave Wishbone arbiter that shares a single memory/IO slave port between the Zet CPU master (m0) and a secondary master such as a VDU or DMA engine (m1). It owns a registered grant state machine and keeps the grant for the whole `cyc` of the owning master. It muxes address, data and control to the slave, routes `ack` back only to the owner, and aborts stalled accesses with a watchdog error. It sits between the masters and a single-ported slave such as the SDRAM controller. `wb_sram` then no longer needs its own dual-port priority logic.

## Interface
Parameters:
- `AW`, 19: address width; addresses are word addresses `[AW:1]`.
- `DW`, 16: data width.
- `SW`, 2: select width, `DW/8`.
- `ARB_MODE`, 0: 0 = round-robin; 1 = fixed priority, m0 wins.
- `TMO_BITS`, 8: watchdog width; timeout fires after `2**TMO_BITS-1` cycles without `ack`.

Ports (x = 0, 1):
- `wb_clk_i` in 1: the single clock.
- `wb_rst_n_i` in 1: asynchronous, active-low reset.
- `mx_adr_i` in AW: master address.
- `mx_dat_i` in DW: write data from master.
- `mx_dat_o` out DW: read data to master.
- `mx_sel_i` in SW: byte selects.
- `mx_we_i` in 1: write enable.
- `mx_tga_i` in 1: 1 = IO space.
- `mx_stb_i` in 1: strobe.
- `mx_cyc_i` in 1: bus cycle.
- `mx_ack_o` out 1: access acknowledge.
- `mx_err_o` out 1: watchdog abort.
- `s_adr_o` out AW, `s_dat_o` out DW, `s_sel_o` out SW, `s_we_o` out 1, `s_tga_o` out 1, `s_stb_o` out 1, `s_cyc_o` out 1: slave-side copies of the owner's signals.
- `s_dat_i` in DW: read data from slave.
- `s_ack_i` in 1: slave acknowledge.
- `gnt_o` out 2: one-hot grant, for debug LEDs.

## Operation
States:
- IDLE: no owner.
- OWN0: m0 owns the slave.
- OWN1: m1 owns the slave.

Arbitration:
- Arbitration is evaluated at an edge where the state is IDLE, or where the current owner has `cyc` low.
- A request is `mx_cyc_i`.
- Only one master requests: grant it.
- Both request, `ARB_MODE`=1: grant m0.
- Both request, `ARB_MODE`=0: grant the master not in `last` (1-bit register, updated on every grant).
- Handoff is direct. If the owner drops `cyc` and the other master is requesting, go OWNx→OWNy in one edge with no IDLE bubble.
- A grant is never revoked while the owner holds `cyc`. Bursts and read-modify-write sequences are atomic.

Mux rules:
- Slave outputs equal the owner's inputs, with `s_stb_o = own_stb & ~abort` and `s_cyc_o = own_cyc`.
- In IDLE all slave outputs are 0.
- `mx_dat_o = s_dat_i` for both masters; data is qualified only by ack.
- `mx_ack_o = s_ack_i & gnt_o[x] & mx_stb_i`. The non-owner never sees an ack.

Watchdog:
- An 8-bit counter `tmo` (width `TMO_BITS`) increments every cycle with `s_stb_o=1` and `s_ack_i=0`.
- It clears on `s_ack_i`, on grant change, and on IDLE.
- At all-ones: assert `mx_err_o` of the owner for exactly one cycle, then set `abort`.
- `abort` masks `s_stb_o` until the owner deasserts `stb` or `cyc`.
- The counter saturates and does not wrap.

Reset:
- Reset puts the block in IDLE.
- `gnt_o`=00, `last`=1 (so m0 wins the first round-robin tie), `tmo`=0, `abort`=0.
- All `ack`/`err`/`s_stb`/`s_cyc` outputs are 0.
- Reset asserted mid-access drops slave `stb`/`cyc` immediately, because the output mux is driven from state.

## Timing
- Grant latency: `cyc` first seen at edge N → `gnt_o` and `s_stb_o` valid after edge N (cycle N+1).
- Ack path: combinational from `s_ack_i` to `mx_ack_o`. Zero added latency once owned, so single-cycle-ack slaves run back-to-back.
- Same-edge events:
  - Owner drop and the other master's request coincide: handoff.
  - Owner drop and its own new request coincide: treated as release. Round-robin then favours the other master if it is requesting.
- `s_ack_i` on the same cycle the watchdog reaches all-ones: the ack wins; err is not raised.
- Slave `ack` while in IDLE or while `abort` is set: ignored.

## Structure
- Shared package `wb_arb_pkg` holds:
  - the state encoding constants `ST_IDLE`, `ST_OWN0`, `ST_OWN1`;
  - the `ARB_MODE` constants `ARB_RR`, `ARB_PRIO`.
- One natural sub-module: `wb_watchdog` (`tmo` counter, `abort` flag, err pulse).
- Grant FSM and mux stay in `wb_arb2`.

## Test plan
- **Reset:** `wb_rst_n_i`=0 → `gnt_o`=00, `s_stb_o`=0, all `ack`/`err` 0. Release, m1 cyc/stb with slave ack at once → `gnt_o`=10 next cycle, `m1_ack_o` pulses, `m0_ack_o` stays 0.
- **Round-robin tie:** `ARB_MODE`=0, both masters raise cyc at the same edge after reset → m0 granted. m0 drops cyc → OWN1 at the next edge, no IDLE cycle.
- **Fixed priority:** `ARB_MODE`=1, m1 repeatedly re-requests and m0 requests continuously → m0 is granted at every arbitration point.
- **Atomic hold:** m1 holds cyc across 4 beats at adr 0x12340 while m0 requests → m0 waits. m0's `s_adr_o` appears only after m1 drops cyc.
- **Watchdog:** `TMO_BITS`=4, slave never acks → `err` asserts for 1 cycle 15 cycles after stb. `s_stb_o`=0 until the master deasserts stb. Ack arriving at count 15 → ack, no err.
- **Mid-access reset:** async reset during OWN0 with stb high → `s_stb_o`/`s_cyc_o` drop without a clock edge, and the state is IDLE after release.
